mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requester ports (2..8).
REQ-002 Parameter RD_LAT, default 1, SHALL set the memory read latency in cycles (1..4), matching the block RAM port-A output latency.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req_i  input  N_REQ  SHALL carry per-requester access request, level, held until ack.
REQ-006 we_i  input  N_REQ  SHALL carry per-requester write enable (1 = write, 0 = read).
REQ-007 addr_i  input  N_REQ x 32  SHALL carry per-requester byte address.
REQ-008 width_i  input  N_REQ x 4  SHALL carry per-requester access width in bytes, passed through unchanged.
REQ-009 wdata_i  input  N_REQ x 32  SHALL carry per-requester write data.
REQ-010 ack_o  output  N_REQ  SHALL pulse one-hot for one cycle on completion.
REQ-011 rdata_o  output  32  SHALL carry read data, valid only in the ack cycle of a read.
REQ-012 mem_ce_o, mem_we_o  output  1 each  SHALL be the memory chip enable and write enable.
REQ-013 mem_addr_o  output  32, mem_width_o  output  4, mem_data_o  output  32  SHALL be the memory address, width and write data.
REQ-014 mem_data_i  input  32  SHALL be the memory read data.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, ACK.
REQ-016 IDLE: if any req_i bit is set, pick a winner round-robin, starting at index (last_grant+1) mod N_REQ; latch its we/addr/width/wdata and index; go to ISSUE. Otherwise stay in IDLE.
REQ-017 last_grant SHALL update to the winner index in the same cycle the winner is latched.
REQ-018 ISSUE: mem_ce_o=1 for exactly one cycle, with the latched fields on the mem_* outputs. A write goes to ACK; a read goes to WAIT.
REQ-019 WAIT: a counter runs RD_LAT-1 further cycles, then the block goes to ACK. With RD_LAT=1, WAIT lasts zero extra cycles and behaves as a single pass-through cycle.
REQ-020 ACK: ack_o[winner]=1 and all other ack bits 0. On a read, rdata_o = mem_data_i sampled RD_LAT cycles after ISSUE. Next state is IDLE.
REQ-021 Read latency from the grant cycle to ack = RD_LAT+2 cycles. Write latency = 2 cycles.
REQ-022 When mem_ce_o=0, mem_we_o SHALL be 0. mem_addr_o, mem_width_o and mem_data_o are don't-care but SHALL hold their latched values.
REQ-023 Only one transaction is in flight at a time. Requests arriving outside IDLE wait.
REQ-024 A requester SHALL drop req_i in the cycle after its ack. A req_i still high in the IDLE cycle after ACK is treated as a new request, subject to round-robin.
REQ-025 If req_i drops before the grant, no access occurs. If req_i drops after the grant, the transaction still completes and ack is still pulsed.
REQ-026 Simultaneous requests from all ports SHALL be served in rotating order. No port waits more than N_REQ-1 transactions.
REQ-027 width_i is not checked. Width 0 SHALL be issued as-is.

Reset
REQ-028 Reset values: state=IDLE, last_grant=N_REQ-1 (port 0 wins first), ack_o=0, rdata_o=0, mem_ce_o=0, mem_we_o=0, mem_addr_o=0, mem_width_o=0, mem_data_o=0.
REQ-029 A reset asserted mid-transaction SHALL abort it: no ack is issued, and mem_ce_o=0 from the cycle after the reset edge.
REQ-030 Reset SHALL take priority over any request present in the same cycle.

Verification
REQ-031 Single read: port 2 reads addr 0x870, memory holds 0xb7acf62c, RD_LAT=1 -> one mem_ce_o pulse with we=0; ack_o=4'b0100 three cycles after the grant; rdata_o=0xb7acf62c.
REQ-032 Single write: port 1 writes 0xdeadbeef to 0x874 with width 4 -> mem_ce_o=mem_we_o=1 for one cycle; ack_o=4'b0010 two cycles after the grant; a read-back returns 0xdeadbeef.
REQ-033 Contention: req_i=4'b1111 held from reset release, all reads -> grants in order 0,1,2,3,0; each ack is one-hot; no two mem_ce_o pulses are closer than RD_LAT+3 cycles.
REQ-034 Fairness after a grant: last_grant=1, req_i=4'b0011 -> port 0 wins before port 1.
REQ-035 Reset mid-read: rst asserted in the WAIT state -> no ack, outputs at reset values, and port 0 wins first after release.
REQ-036 Latency sweep: RD_LAT=3 -> read ack five cycles after the grant with correct data; write ack stays at two cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising N_REQ requesters onto one single-port memory, one access in flight.
// Grant -> ISSUE -> WAIT x RD_LAT (reads only) -> ACK; losing requesters simply hold req_i until served.
module mem_arbiter #(
  parameter int N_REQ  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ-1:0]       we_i,
  input  logic [N_REQ-1:0][31:0] addr_i,
  input  logic [N_REQ-1:0][3:0]  width_i,
  input  logic [N_REQ-1:0][31:0] wdata_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic [31:0]            rdata_o,
  output logic                   mem_ce_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [3:0]             mem_width_o,
  output logic [31:0]            mem_data_o,
  input  logic [31:0]            mem_data_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_we;
  logic             found;
  logic [IDX_W:0]   cand;
  logic [2:0]       wait_cnt;

  // Scan starts one past the previous winner so every port is reached within N_REQ grants.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_ce_o  = 1'b0;
    mem_we_o  = 1'b0;
    ack_o     = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_ce_o  = 1'b1;
        mem_we_o  = cur_we;
        state_nxt = cur_we ? ACK : WAIT;
      end
      WAIT: begin
        if (wait_cnt == 3'(RD_LAT - 1)) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        ack_o[cur_idx] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Winner fields are latched at grant and held on the mem_* bus until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= IDX_W'(N_REQ - 1);
      cur_idx     <= '0;
      cur_we      <= 1'b0;
      mem_addr_o  <= '0;
      mem_width_o <= '0;
      mem_data_o  <= '0;
      wait_cnt    <= '0;
      rdata_o     <= '0;
    end else begin
      if (state == IDLE && found) begin
        last_grant  <= win_idx;
        cur_idx     <= win_idx;
        cur_we      <= we_i[win_idx];
        mem_addr_o  <= addr_i[win_idx];
        mem_width_o <= width_i[win_idx];
        mem_data_o  <= wdata_i[win_idx];
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 3'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (state == WAIT && state_nxt == ACK) begin
        rdata_o <= mem_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives two arbiters (RD_LAT=1 and RD_LAT=3) with shared requests against behavioural memories.
// Expected winners, latencies and read data come from a round-robin rule and a flat reference memory.
module tb_mem_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [N-1:0]        req;
  logic [N-1:0]        we;
  logic [N-1:0][31:0]  addr;
  logic [N-1:0][3:0]   width;
  logic [N-1:0][31:0]  wdata;

  logic [N-1:0] ack1, ack3;
  logic [31:0]  rdata1, rdata3;
  logic         ce1, ce3, mwe1, mwe3;
  logic [31:0]  maddr1, maddr3, mdo1, mdo3, mdi1, mdi3;
  logic [3:0]   mw1, mw3;

  int tests_run    = 0;
  int tests_failed = 0;
  int last_model;

  logic [31:0] mem1    [0:1023];
  logic [31:0] mem3    [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] pipe1;
  logic [31:0] pipe3   [0:2];

  mem_arbiter #(.N_REQ(N), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .width_i(width),
    .wdata_i(wdata), .ack_o(ack1), .rdata_o(rdata1), .mem_ce_o(ce1), .mem_we_o(mwe1),
    .mem_addr_o(maddr1), .mem_width_o(mw1), .mem_data_o(mdo1), .mem_data_i(mdi1)
  );

  mem_arbiter #(.N_REQ(N), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .width_i(width),
    .wdata_i(wdata), .ack_o(ack3), .rdata_o(rdata3), .mem_ce_o(ce3), .mem_we_o(mwe3),
    .mem_addr_o(maddr3), .mem_width_o(mw3), .mem_data_o(mdo3), .mem_data_i(mdi3)
  );

  // Block RAM models: address sampled on the ISSUE edge, data visible RD_LAT cycles after ISSUE.
  always @(posedge clk) begin
    if (ce1) begin
      if (mwe1) mem1[maddr1[11:2]] <= mdo1;
      else      pipe1 <= mem1[maddr1[11:2]];
    end
  end
  assign mdi1 = pipe1;

  always @(posedge clk) begin
    if (ce3 && mwe3) mem3[maddr3[11:2]] <= mdo3;
    if (ce3 && !mwe3) pipe3[0] <= mem3[maddr3[11:2]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mdi3 = pipe3[2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ":d1"}, 128'({ack1, ce1, mwe1, maddr1, mw1, mdo1, rdata1}), 128'd0);
    chk({tag, ":d3"}, 128'({ack3, ce3, mwe3, maddr3, mw3, mdo3, rdata3}), 128'd0);
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] m);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  // One arbitration: mask is presented for the grant cycle, then only the winner keeps requesting.
  task automatic txn(input logic [N-1:0] mask, input string tag);
    int w, l1, l3, na1, na3, nc1, nc3, c1, c3, bad_we;
    logic        is_wr;
    logic [31:0] exp_rd;
    logic [N-1:0] exp_ack;
    w = rr_pick(last_model, mask);
    last_model = w;
    is_wr   = we[w];
    exp_rd  = ref_mem[addr[w][11:2]];
    exp_ack = N'(1 << w);
    l1 = 0; l3 = 0; na1 = 0; na3 = 0; nc1 = 0; nc3 = 0; c1 = 0; c3 = 0; bad_we = 0;
    req = mask;
    @(posedge clk); #1;
    req    = '0;
    req[w] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if ((mwe1 && !ce1) || (mwe3 && !ce3)) bad_we++;
      if (ce1) begin
        nc1++;
        if (nc1 == 1) begin
          c1 = n;
          chk({tag, ":issue1"}, 128'({mwe1, mw1, maddr1, mdo1}), 128'({is_wr, width[w], addr[w], wdata[w]}));
        end
      end
      if (ce3) begin
        nc3++;
        if (nc3 == 1) begin
          c3 = n;
          chk({tag, ":issue3"}, 128'({mwe3, mw3, maddr3, mdo3}), 128'({is_wr, width[w], addr[w], wdata[w]}));
        end
      end
      if (ack3 != '0) begin
        na3++;
        if (na3 == 1) begin
          l3 = n;
          chk({tag, ":ack3"}, 128'(ack3), 128'(exp_ack));
          if (!is_wr) chk({tag, ":rdata3"}, 128'(rdata3), 128'(exp_rd));
        end
      end
      if (ack1 != '0) begin
        na1++;
        if (na1 == 1) begin
          l1 = n;
          chk({tag, ":ack1"}, 128'(ack1), 128'(exp_ack));
          if (!is_wr) chk({tag, ":rdata1"}, 128'(rdata1), 128'(exp_rd));
        end
        req = '0;
      end
    end
    req = '0;
    chk({tag, ":lat1"}, 128'(l1), 128'(is_wr ? 2 : 3));
    chk({tag, ":lat3"}, 128'(l3), 128'(is_wr ? 2 : 5));
    chk({tag, ":counts"}, 128'({8'(na1), 8'(na3), 8'(nc1), 8'(nc3), 8'(c1), 8'(c3), 8'(bad_we)}),
        128'({8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0}));
    if (is_wr) ref_mem[addr[w][11:2]] = wdata[w];
  endtask

  initial begin
    logic [31:0] v;
    logic [N-1:0] exp_ord [0:4];
    logic [N-1:0] ord1 [0:4];
    logic [N-1:0] ord3 [0:4];
    int k1, k3, prev1, prev3, gap1, gap3, bad_oh;

    rst = 1'b1; req = '0; we = '0; addr = '0; width = '0; wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      mem1[i] = v; mem3[i] = v; ref_mem[i] = v;
    end
    mem1[10'h21C] = 32'hb7acf62c; mem3[10'h21C] = 32'hb7acf62c; ref_mem[10'h21C] = 32'hb7acf62c;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    last_model = N - 1;

    // Directed single read, write, read-back and post-grant fairness.
    we[2] = 1'b0; addr[2] = 32'h870; width[2] = 4'd4; wdata[2] = 32'h0;
    txn(4'b0100, "rd_p2");
    we[1] = 1'b1; addr[1] = 32'h874; width[1] = 4'd4; wdata[1] = 32'hdeadbeef;
    txn(4'b0010, "wr_p1");
    we[1] = 1'b0;
    txn(4'b0010, "rb_p1");
    chk("rb_value", 128'(ref_mem[10'h21D]), 128'(32'hdeadbeef));
    we[0] = 1'b0; addr[0] = 32'h10;
    txn(4'b0011, "fair_a");
    txn(4'b0011, "fair_b");

    // Randomised masks, directions, addresses and widths (width 0 included).
    for (int t = 0; t < 24; t++) begin
      for (int p = 0; p < N; p++) begin
        we[p]    = 1'($urandom_range(0, 1));
        addr[p]  = $urandom;
        width[p] = 4'($urandom_range(0, 15));
        wdata[p] = $urandom;
      end
      txn(N'($urandom_range(1, (1 << N) - 1)), $sformatf("rand%0d", t));
    end

    // Abort a read in WAIT, then hold requests through reset.
    we[3] = 1'b0; addr[3] = 32'h40;
    req = 4'b1000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    req = 4'b1111;
    @(negedge clk);
    chk_reset("abort");
    @(posedge clk);
    @(negedge clk);
    chk_reset("rst_prio");
    rst = 1'b0; req = '0; last_model = N - 1;
    @(negedge clk);
    for (int p = 0; p < N; p++) we[p] = 1'b0;
    txn(4'b1111, "post_rst");

    // All ports requesting continuously from reset release.
    exp_ord[0] = 4'b0001; exp_ord[1] = 4'b0010; exp_ord[2] = 4'b0100;
    exp_ord[3] = 4'b1000; exp_ord[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin ord1[i] = '0; ord3[i] = '0; end
    k1 = 0; k3 = 0; prev1 = -1; prev3 = -1; gap1 = 1000; gap3 = 1000; bad_oh = 0;
    rst = 1'b1; req = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ce1) begin
        if (prev1 >= 0 && n - prev1 < gap1) gap1 = n - prev1;
        prev1 = n;
      end
      if (ce3) begin
        if (prev3 >= 0 && n - prev3 < gap3) gap3 = n - prev3;
        prev3 = n;
      end
      if (ack1 != '0) begin
        if (!$onehot(ack1)) bad_oh++;
        if (k1 < 5) ord1[k1] = ack1;
        k1++;
      end
      if (ack3 != '0) begin
        if (!$onehot(ack3)) bad_oh++;
        if (k3 < 5) ord3[k3] = ack3;
        k3++;
      end
    end
    req = '0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("cont1_ord%0d", i), 128'(ord1[i]), 128'(exp_ord[i]));
      chk($sformatf("cont3_ord%0d", i), 128'(ord3[i]), 128'(exp_ord[i]));
    end
    chk("cont_onehot", 128'(bad_oh), 128'd0);
    chk("cont1_gap", 128'(gap1 >= 4), 128'd1);
    chk("cont3_gap", 128'(gap3 >= 6), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
